// File: rtl/opb_sw_reg_bank_if.sv
// OPB bus bundle between the PPC master side and the register bank slave.
// Bit 0 is the MSB on every vector, following OPB numbering.
interface opb_sw_reg_bank_if;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );
endinterface

// File: rtl/opb_sw_reg_bank.sv
// OPB slave register bank: C_NUM_REGS control words plus a commit register,
// with optional shadow staging so a group of words changes on a single commit.
//
// state  | meaning
// S_IDLE | waiting for select on a decoded address
// S_ACK  | single acknowledge cycle; read data driven
// S_HOLD | waiting for the master to drop select
module opb_sw_reg_bank #(
   parameter logic [31:0] C_BASEADDR   = 32'h0108_3900,
   parameter logic [31:0] C_HIGHADDR   = 32'h0108_39FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_NUM_REGS   = 4,
   parameter logic [31:0] C_RESET_VAL  = 32'h0,
   parameter int          C_SHADOW     = 0,
   parameter string       C_FAMILY     = "virtex6"
) (
   input  logic                     OPB_Clk,
   input  logic                     OPB_Rst,
   opb_sw_reg_bank_if.slave         opb,
   output logic [C_NUM_REGS*32-1:0] user_data_out,
   output logic [C_NUM_REGS-1:0]    user_data_valid,
   output logic                     user_commit
);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

   state_t state, state_nxt;
   logic   start;

   logic [C_OPB_AWIDTH-1:0] addr, addr_rel, word_off;
   logic                    hit, cmt_hit;
   logic [C_NUM_REGS-1:0]   reg_hot;
   logic [C_OPB_DWIDTH-1:0] wdata;
   logic [3:0]              be;

   logic [C_NUM_REGS-1:0][31:0] live;
   logic [C_NUM_REGS-1:0][31:0] shadow;
   logic [C_NUM_REGS-1:0]       dirty;
   logic [31:0]                 commit_cnt;

   logic                    rnw_q;
   logic                    cmt_q;
   logic [C_NUM_REGS-1:0]   reg_sel_q;
   logic [C_OPB_DWIDTH-1:0] rd_data;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  en);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = en[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      return res;
   endfunction

   // Bus vectors are MSB-at-0, so plain assignment lands OPB bit 0 on bit 31
   // and BE[0] on be[3], the most significant byte.
   assign addr     = opb.OPB_ABus;
   assign wdata    = opb.OPB_DBus;
   assign be       = opb.OPB_BE;
   assign addr_rel = addr - C_BASEADDR;
   assign word_off = addr_rel >> 2;
   assign hit      = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
   assign cmt_hit  = hit && (word_off == C_OPB_AWIDTH'(C_NUM_REGS));

   always_comb begin
      reg_hot = '0;
      for (int i = 0; i < C_NUM_REGS; i++)
         reg_hot[i] = hit && (word_off == C_OPB_AWIDTH'(i));
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         S_IDLE: if (opb.OPB_select && hit) begin
            start     = 1'b1;
            state_nxt = S_ACK;
         end
         S_ACK:  state_nxt = S_HOLD;
         S_HOLD: if (!opb.OPB_select) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         live            <= {C_NUM_REGS{C_RESET_VAL}};
         shadow          <= {C_NUM_REGS{C_RESET_VAL}};
         dirty           <= '0;
         commit_cnt      <= '0;
         user_data_valid <= '0;
         user_commit     <= 1'b0;
         rnw_q           <= 1'b0;
         cmt_q           <= 1'b0;
         reg_sel_q       <= '0;
      end else begin
         user_data_valid <= '0;
         user_commit     <= 1'b0;
         if (start) begin
            rnw_q     <= opb.OPB_RNW;
            cmt_q     <= cmt_hit;
            reg_sel_q <= reg_hot;
            if (!opb.OPB_RNW) begin
               for (int i = 0; i < C_NUM_REGS; i++) begin
                  if (reg_hot[i]) begin
                     if (C_SHADOW != 0) begin
                        shadow[i] <= byte_merge(shadow[i], wdata, be);
                        dirty[i]  <= 1'b1;
                     end else begin
                        live[i]            <= byte_merge(live[i], wdata, be);
                        user_data_valid[i] <= 1'b1;
                     end
                  end
               end
               if (cmt_hit) begin
                  user_commit <= 1'b1;
                  commit_cnt  <= commit_cnt + 32'd1;
                  if (C_SHADOW != 0) begin
                     for (int i = 0; i < C_NUM_REGS; i++)
                        if (dirty[i]) live[i] <= shadow[i];
                     user_data_valid <= dirty;
                     dirty           <= '0;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < C_NUM_REGS; i++)
         if (reg_sel_q[i]) rd_data = rd_data | ((C_SHADOW != 0) ? shadow[i] : live[i]);
      if (cmt_q) rd_data = rd_data | commit_cnt;
   end

   assign user_data_out  = live;
   assign opb.Sl_xferAck = (state == S_ACK);
   // Wired-OR bus: drive zero everywhere except the read acknowledge cycle.
   assign opb.Sl_DBus    = (state == S_ACK && rnw_q) ? rd_data : '0;
   assign opb.Sl_errAck  = 1'b0;
   assign opb.Sl_retry   = 1'b0;
   assign opb.Sl_toutSup = 1'b0;

endmodule

// File: doc/opb_sw_reg_bank.md
# opb_sw_reg_bank

Parametrised PPC-to-fabric software register bank on the OPB bus. It is the multi-register successor to the single-word ppc2simulink register: one OPB slave decodes `C_NUM_REGS` 32-bit control words plus a commit register. It supports byte-enable writes and readback. An optional shadow mode makes a group of registers update atomically on a single commit. It sits between the PPC OPB bus and the DSP control inputs (for example ADC phase/position and DDS settings) and runs entirely in the OPB clock domain.

## Interface
Parameters:
- `C_BASEADDR`, default 32'h01083900: first byte address.
- `C_HIGHADDR`, default 32'h010839FF: last decoded byte address; must cover 4*(`C_NUM_REGS`+1) bytes.
- `C_OPB_AWIDTH`, default 32: OPB address width.
- `C_OPB_DWIDTH`, default 32: OPB data width (fixed 32).
- `C_NUM_REGS`, default 4: number of user registers, 1..16.
- `C_RESET_VAL`, default 32'h0: reset value of every register.
- `C_SHADOW`, default 0: 0 means immediate update; 1 means writes stage into shadows and apply on commit.
- `C_FAMILY`, default "virtex6": target family string.

Ports:
- `OPB_Clk`, in, 1: the single clock. One clock; reset is synchronous and active-high.
- `OPB_Rst`, in, 1: synchronous, active-high reset.
- `OPB_ABus`, in, [0:31]: address.
- `OPB_BE`, in, [0:3]: byte enables; BE[0] selects DBus[0:7] (MSB byte).
- `OPB_DBus`, in, [0:31]: write data.
- `OPB_RNW`, in, 1: 1 = read.
- `OPB_select`, in, 1: transfer in progress.
- `OPB_seqAddr`, in, 1: ignored; every beat is handled as a single transfer.
- `Sl_DBus`, out, [0:31]: read data.
- `Sl_xferAck`, out, 1: transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup`, out, 1 each: tied 0.
- `user_data_out`, out, `C_NUM_REGS`*32: register i is on bits [32i+31:32i]; `OPB_DBus`[0] maps to bit 32i+31.
- `user_data_valid`, out, `C_NUM_REGS`: one-cycle pulse per register whose output changed value source (written, or committed).
- `user_commit`, out, 1: one-cycle pulse on each commit-register write.

## Operation
- Address map (word offsets from `C_BASEADDR`):
  - offset i, for i < `C_NUM_REGS`: register i.
  - offset `C_NUM_REGS`: commit register.
  - Higher offsets up to `C_HIGHADDR` are acknowledged; they read 0 and ignore writes.
  - Addresses outside [`C_BASEADDR`,`C_HIGHADDR`] are never acknowledged.
- Slave FSM has three states:
  - IDLE: on `OPB_select` & hit, capture offset/RNW/BE/DBus and go to ACK.
  - ACK: lasts exactly 1 cycle; go to HOLD.
  - HOLD: stay while `OPB_select`=1; go to IDLE when it drops. This prevents a double acknowledge.
- Writes, immediate mode (`C_SHADOW`=0):
  - Register bytes whose BE=1 update at the edge entering ACK; other bytes are kept.
  - `user_data_valid[i]` pulses during the ACK cycle, even if BE=0000.
- Writes, shadow mode (`C_SHADOW`=1):
  - The byte-merge goes into shadow i and sets dirty[i]; `user_data_out` is unchanged.
- Commit write (any BE):
  - `user_commit` pulses during the ACK cycle.
  - In shadow mode, every dirty shadow is copied to its output at the same edge, `user_data_valid` pulses for the dirty set, and all dirty bits clear.
  - The 32-bit commit counter increments, wrapping at 2^32-1 to 0.
- Reads:
  - Register offset returns the shadow in shadow mode, otherwise the live value.
  - Commit offset returns the commit counter.
- `Sl_DBus` is 0 in every cycle except a read ACK (wired-OR bus).

## Timing
- Reset values:
  - `Sl_DBus`=0 and `Sl_xferAck`=0.
  - `user_data_out` = `C_RESET_VAL` replicated.
  - `user_data_valid`=0, `user_commit`=0.
  - Shadows = `C_RESET_VAL`, dirty=0, commit counter=0, FSM=IDLE.
- Acknowledge latency: `Sl_xferAck` is high in the cycle after `OPB_select`&hit is first sampled; exactly one cycle per transfer.
- Immediate-mode write: the new `user_data_out` value appears in the ACK cycle (1 cycle after select).
- Shadow-mode commit: outputs change in the commit ACK cycle; all registers update on the same edge.
- Reset asserted mid-transfer (ACK or HOLD): next state is IDLE with no ack; the pending write is discarded and all registers reset.
- A fresh transfer is accepted only after `OPB_select` is low for ≥1 cycle.

## Test plan
- Reset, then read offsets 0..`C_NUM_REGS`: all return `C_RESET_VAL`; commit offset returns 0; `Sl_DBus`=0 outside ACK.
- Immediate mode, write 0xDEADBEEF to reg 2 with BE=1111, then write 0x00000011 with BE=0001: reg 2 reads 0xDEADBE11; ack comes 1 cycle after select; `user_data_valid`=0b0100 for one cycle each time.
- Shadow mode, write reg0=0x1 and reg3=0x3: outputs stay 0 and readback gives 0x1/0x3. Commit write: both outputs update on the same edge, `user_data_valid`=0b1001, `user_commit`=1, counter reads 1.
- Hold `OPB_select` high for 5 cycles: exactly one `Sl_xferAck`. Access to `C_HIGHADDR`+4: no ack.
- Preload counter 0xFFFFFFFF via 2^32-1 commits (force in bench), commit once more: counter reads 0.
- Assert `OPB_Rst` in the ACK cycle of a write of 0xA5A5A5A5: register reads `C_RESET_VAL` afterwards, FSM is IDLE, and the next transfer acks normally.
